mpe_operand_feeder: RTL

Operand transmitter for the matrix PE. It accepts one matmul command: beat count, NRAM base and WRAM base. It reads paired 512-bit neuron/weight words from NRAM and WRAM, which are synchronous SRAMs with 1-cycle read latency, and streams them to the matrix PE together with the 8-bit uop (beat count). It follows the PE beat/retire protocol. It sits between the command controller and the matrix PE, and drives the PE's `nram_mpe_neuron*`, `wram_mpe_weight*` and `ib_ctl_uop*` inputs.

---
 rtl/mpe_operand_feeder_if.sv | 64 ++++++
 rtl/mpe_operand_feeder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mpe_operand_feeder_if.sv
// Command, SRAM read and matrix-PE operand bundle for the operand feeder.
// master = feeder side, slave = controller/SRAM/PE side.
interface mpe_operand_feeder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 512
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_len;
  logic [ADDR_W-1:0] cmd_nram_base;
  logic [ADDR_W-1:0] cmd_wram_base;

  logic              nram_rd_en;
  logic [ADDR_W-1:0] nram_rd_addr;
  logic [DATA_W-1:0] nram_rd_data;
  logic              wram_rd_en;
  logic [ADDR_W-1:0] wram_rd_addr;
  logic [DATA_W-1:0] wram_rd_data;

  logic [DATA_W-1:0] mpe_neuron;
  logic              mpe_neuron_valid;
  logic              mpe_neuron_ready;
  logic [DATA_W-1:0] mpe_weight;
  logic              mpe_weight_valid;
  logic              mpe_weight_ready;
  logic [7:0]        ctl_uop;
  logic              ctl_uop_valid;
  logic              ctl_uop_ready;
  logic              done;

  modport master (
    input  cmd_valid, cmd_len,
    input  cmd_nram_base, cmd_wram_base,
    output cmd_ready,
    output nram_rd_en, nram_rd_addr,
    input  nram_rd_data,
    output wram_rd_en, wram_rd_addr,
    input  wram_rd_data,
    output mpe_neuron, mpe_neuron_valid,
    input  mpe_neuron_ready,
    output mpe_weight, mpe_weight_valid,
    input  mpe_weight_ready,
    output ctl_uop, ctl_uop_valid,
    input  ctl_uop_ready,
    output done
  );

  modport slave (
    output cmd_valid, cmd_len,
    output cmd_nram_base, cmd_wram_base,
    input  cmd_ready,
    input  nram_rd_en, nram_rd_addr,
    output nram_rd_data,
    input  wram_rd_en, wram_rd_addr,
    output wram_rd_data,
    input  mpe_neuron, mpe_neuron_valid,
    output mpe_neuron_ready,
    input  mpe_weight, mpe_weight_valid,
    output mpe_weight_ready,
    input  ctl_uop, ctl_uop_valid,
    output ctl_uop_ready,
    input  done
  );
endinterface

// File: rtl/mpe_operand_feeder.sv
// Matrix-PE operand feeder: reads paired NRAM/WRAM words and streams
// them to the PE through a 2-entry buffer, one beat per un-retired cycle.
module mpe_operand_feeder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mpe_operand_feeder_if.master  io
);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    STREAM,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [ADDR_W-1:0] nbase_q, nbase_d;
  logic [ADDR_W-1:0] wbase_q, wbase_d;
  logic [7:0]        rd_cnt_q, rd_cnt_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] nbuf_q [2];
  logic [DATA_W-1:0] wbuf_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic       active;
  logic       retire;
  logic       beat_vld;
  logic       pop;
  logic       push;
  logic [2:0] pend;
  logic       space;
  logic       rd_fire;
  logic       unused_rdy;

  assign unused_rdy = io.mpe_neuron_ready & io.mpe_weight_ready;

  assign active   = (state_q != IDLE);
  assign retire   = active & io.ctl_uop_ready;
  assign beat_vld = (state_q == STREAM) & (occ_q != 2'd0);
  assign pop      = beat_vld & ~io.ctl_uop_ready;
  // data returning on a retire cycle belongs to a cancelled command
  assign push     = inflight_q & ~retire;

  assign pend  = {1'b0, occ_q} + {2'b0, inflight_q};
  assign space = pend < (3'd2 + {2'b0, pop});

  assign rd_fire = ((state_q == LEAD) | (state_q == STREAM))
                 & ~io.ctl_uop_ready
                 & (rd_cnt_q < len_q)
                 & space;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    nbase_d    = nbase_q;
    wbase_d    = wbase_q;
    rd_cnt_d   = rd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.cmd_valid) begin
          len_d      = io.cmd_len;
          nbase_d    = io.cmd_nram_base;
          wbase_d    = io.cmd_wram_base;
          rd_cnt_d   = 8'd0;
          beat_cnt_d = 8'd0;
          if (io.cmd_len == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = LEAD;
          end
        end
      end
      LEAD: state_d = STREAM;
      STREAM: begin
        if (pop && (beat_cnt_q == len_q - 8'd1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (rd_fire) rd_cnt_d = rd_cnt_q + 8'd1;
    if (pop) beat_cnt_d = beat_cnt_q + 8'd1;
    if (retire) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_comb begin
    inflight_d = rd_fire;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (retire) begin
      inflight_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      occ_d      = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      nbase_q    <= '0;
      wbase_q    <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      nbase_q    <= nbase_d;
      wbase_q    <= wbase_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbuf_q[0] <= '0;
      nbuf_q[1] <= '0;
      wbuf_q[0] <= '0;
      wbuf_q[1] <= '0;
    end else if (push) begin
      nbuf_q[wr_ptr_q] <= io.nram_rd_data;
      wbuf_q[wr_ptr_q] <= io.wram_rd_data;
    end
  end

  assign io.cmd_ready    = (state_q == IDLE);
  assign io.nram_rd_en   = rd_fire;
  assign io.wram_rd_en   = rd_fire;
  assign io.nram_rd_addr = nbase_q + ADDR_W'(rd_cnt_q);
  assign io.wram_rd_addr = wbase_q + ADDR_W'(rd_cnt_q);

  // buffer contents are hidden while no beat is offered
  assign io.mpe_neuron       = beat_vld ? nbuf_q[rd_ptr_q] : '0;
  assign io.mpe_weight       = beat_vld ? wbuf_q[rd_ptr_q] : '0;
  assign io.mpe_neuron_valid = beat_vld;
  assign io.mpe_weight_valid = beat_vld;
  assign io.ctl_uop          = len_q;
  assign io.ctl_uop_valid    = active;
  assign io.done             = done_q;

endmodule
